load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_align.sv | 29 ++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3, FSM state and byte-enable encodings for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H    = 4'b0011;
  localparam logic [3:0] BE_W    = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == F3_H[1:0] && off[0]) || (f3[1:0] == F3_W[1:0] && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering / byte enables and load lane select with sign or zero extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);
  logic        is_b;
  logic        is_h;
  logic        sext;
  logic [31:0] shifted;
  // size decode drives both the store replication and the load extension
  always_comb begin
    is_b     = funct3[1:0] == F3_B[1:0];
    is_h     = funct3[1:0] == F3_H[1:0];
    sext     = ~funct3[2];
    st_wdata = is_b ? {4{st_data[7:0]}} : is_h ? {2{st_data[15:0]}} : st_data;
    st_be    = is_b ? BE_B << off : is_h ? BE_H << off : BE_W;
    shifted  = ld_raw >> {off, 3'b000};
    ld_data  = is_b ? {{24{sext & shifted[7]}}, shifted[7:0]}
             : is_h ? {{16{sext & shifted[15]}}, shifted[15:0]}
             : shifted;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage load/store FSM bridging the pipeline to a valid/ready bus with read timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_M,
  input  logic [ADDR_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic                  o_req_valid,
  output logic                  o_req_we,
  input  logic                  i_req_ready,
  output logic [ADDR_WIDTH-1:0] o_req_addr,
  output logic [DATA_WIDTH-1:0] o_req_wdata,
  output logic [3:0]            o_req_be,
  input  logic                  i_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_rsp_rdata,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_misaligned,
  output logic                  o_fault
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mis_q, mis_d;
  logic                  fault_q, fault_d;
  logic                  req;
  logic                  bad;
  logic                  mis;
  logic                  start;
  logic [3:0]            be_raw;
  logic [DATA_WIDTH-1:0] ld_data;

  lsu_align u_align (
    .funct3   (f3_q),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_raw   (i_rsp_rdata),
    .st_wdata (o_req_wdata),
    .st_be    (be_raw),
    .ld_data  (ld_data)
  );

  // request screening in IDLE, then next-state, capture and pulse logic
  always_comb begin
    req     = i_mem_read_M | i_mem_write_M;
    bad     = (i_mem_read_M & i_mem_write_M) | (req & ~f3_legal(i_funct3_M));
    mis     = req & ~bad & f3_misaligned(i_funct3_M, i_addr_M[1:0]);
    start   = (state_q == IDLE) & req & ~bad & ~mis;
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        mis_d   = mis;
        fault_d = bad;
        if (start) begin
          state_d = REQ;
          addr_d  = i_addr_M;
          wdata_d = i_write_data_M;
          f3_d    = i_funct3_M;
          we_d    = i_mem_write_M;
          cnt_d   = 16'd0;
        end
      end
      REQ: begin
        if (i_req_ready) begin
          state_d = (we_q | i_rsp_valid) ? DONE : WAIT_RSP;
          rdata_d = (~we_q & i_rsp_valid) ? ld_data : rdata_q;
        end
      end
      WAIT_RSP: begin
        if (i_rsp_valid) begin
          state_d = DONE;
          rdata_d = ld_data;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = DONE;
          rdata_d = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and captured-field registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      cnt_q   <= 16'd0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  // bus and pipeline outputs; loads drive no byte enables
  always_comb begin
    o_req_valid   = state_q == REQ;
    o_req_we      = we_q;
    o_req_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    o_req_be      = we_q ? be_raw : BE_NONE;
    o_stall       = start | (state_q == REQ) | (state_q == WAIT_RSP);
    o_read_data_M = rdata_q;
    o_misaligned  = mis_q;
    o_fault       = fault_q;
  end
endmodule
